// File: rtl/prbs_pkg.sv
// Shared types and tap constants for the serial PRBS checker family.
package prbs_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Two-tap maximal-length polynomials (1-based taps, MSB = 1).
    localparam int TAP3_A = 3;
    localparam int TAP3_B = 2;
    localparam int TAP7_A = 7;
    localparam int TAP7_B = 6;

    // x^8+x^6+x^5+x^4+1 needs four taps; reserved for a multi-tap variant.
    localparam int TAP8_A = 8;
    localparam int TAP8_B = 6;
    localparam int TAP8_C = 5;
    localparam int TAP8_D = 4;

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module prbs_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker with flywheel lock and saturating error count.
// Optional PRBS_CHK_BITCNT_EN adds a saturating count of bits received while locked.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int N        = TAP7_A,
    parameter int TAP_A    = TAP7_A,
    parameter int TAP_B    = TAP7_B,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [CNT_W+8-1:0] bit_count
`endif
);

    localparam int FILL_W  = $clog2(N + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    state_e             state_q, state_d;
    logic [N-1:0]       hist_q, hist_d;   // hist_q[k-1] holds s[k]; s[1] is newest
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               locked_q;
    logic               err_pulse_q;
    logic               err_inc;

    logic pred;
    logic mism;
    logic hist_zero;

    assign pred      = hist_q[TAP_A-1] ^ hist_q[TAP_B-1];
    assign mism      = in_bit ^ pred;
    assign hist_zero = (hist_q == '0);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_inc = 1'b0;

        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    hist_d = {hist_q[N-2:0], in_bit};
                    if (fill_q == FILL_W'(N - 1)) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                VERIFY: begin
                    hist_d = {hist_q[N-2:0], in_bit};
                    if (hist_zero) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                    end else if (mism) begin
                        match_d = '0;
                    end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        match_d = '0;
                        miss_d  = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                LOCKED: begin
                    // Flywheel: history advances on the prediction, not the received bit.
                    hist_d = {hist_q[N-2:0], pred};
                    if (hist_zero) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                        miss_d  = '0;
                    end else if (mism) begin
                        err_inc = 1'b1;
                        if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
                            state_d = SEARCH;
                            fill_d  = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SEARCH;
            hist_q      <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= (state_d == LOCKED);
            err_pulse_q <= err_inc;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

    prbs_sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (clear),
        .inc_i   (err_inc),
        .count_o (err_count)
    );

`ifdef PRBS_CHK_BITCNT_EN
    prbs_sat_counter #(
        .W (CNT_W + 8)
    ) u_bit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (clear),
        .inc_i   (in_valid && (state_q == LOCKED)),
        .count_o (bit_count)
    );
`endif

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial PRBS checker placed directly downstream of the Fibonacci LFSR generator.
- Consumes the generator's feedback-bit stream, self-synchronises to it, then flags and counts bit errors against a locally predicted sequence.
- Used in loopback/BIST paths.
- Lock status and the error count feed the status register block.

Parameters:
- N, 7, LFSR length; legal 3..32.
- TAP_A, 7, first feedback tap (1-based, MSB=1 convention); must equal N.
- TAP_B, 6, second feedback tap; 1 <= TAP_B < N. Defaults give maximal-length x^7+x^6+1.
- LOCK_CNT, 8, consecutive matching bits needed to declare lock; >= 1.
- LOSS_CNT, 4, consecutive mismatches in LOCKED that drop lock; >= 1.
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  qualifies in_bit. The block only advances on in_valid=1.
- in_bit  in  1  received PRBS bit (newest feedback bit from upstream).
- clear  in  1  synchronous clear of err_count; does not affect lock.
- locked  out  1  high while in LOCKED state.
- err_pulse  out  1  one-cycle pulse per detected error in LOCKED.
- err_count  out  CNT_W  saturating error count.

Behaviour:
- History register s[1:N], where s[1] is the newest bit. Prediction p = s[TAP_A] ^ s[TAP_B]. A mismatch is m = in_bit ^ p.
- States:
  - SEARCH: fill s. Counter fill_cnt counts valid bits. Each valid bit shifts in_bit into s[1]. After the N-th valid bit, go to VERIFY with match_cnt=0.
  - VERIFY: each valid bit shifts in_bit into s.
    - Match: match_cnt++.
    - Mismatch: match_cnt=0 and stay in VERIFY. No re-fill is needed; the history re-seeds itself.
    - When match_cnt reaches LOCK_CNT, go to LOCKED.
  - LOCKED (flywheel): each valid bit shifts p, not in_bit, into s, so isolated errors do not corrupt the history.
    - Mismatch: err_pulse=1 next cycle, err_count++ (saturating at all-ones), miss_cnt++.
    - Match: miss_cnt=0.
    - When miss_cnt reaches LOSS_CNT, go to SEARCH with fill_cnt=0.
- All-zero history detected in VERIFY or LOCKED forces SEARCH (stuck-zero stream can never be valid).
- in_valid=0: no state, counter or history change; err_pulse=0.
- Timing: all outputs are registered.
  - locked rises at the clock edge that samples valid bit number N+LOCK_CNT (the 15th with defaults) of a clean stream.
  - locked falls at the edge sampling the LOSS_CNT-th consecutive mismatch.
  - err_pulse is high for the cycle following the edge that sampled the error.
  - The error that causes loss of lock is still counted.
- Errors in SEARCH/VERIFY are never counted and never pulse.
- clear has priority over a same-cycle error: err_count=0 and the error is not counted. err_pulse still fires.
- Reset (asynchronous, any time, including mid-lock):
  - state=SEARCH; s, fill_cnt, match_cnt, miss_cnt = 0.
  - locked=0, err_pulse=0, err_count=0.
- Counter widths: clog2(N+1), clog2(LOCK_CNT+1), clog2(LOSS_CNT+1).

Optional Feature:
- PRBS_CHK_BITCNT_EN defined: adds output bit_count [CNT_W+8-1:0].
  - Increments on every valid bit while LOCKED; saturates at all-ones.
  - Cleared by clear and by reset. Kept (not cleared) on loss of lock.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package prbs_pkg holds:
  - state enum {SEARCH, VERIFY, LOCKED}, 2 bits.
  - Default tap constants for N=3 (3,2), 7 (7,6) and 8 (8,6,5,4 noted for future multi-tap variant).
- Sub-module prbs_sat_counter is natural: parameterised width, inc, clr with clr priority, saturating. Instantiated for err_count and, when enabled, bit_count.

Test Plan:
1. Reset, then feed a clean x^7+x^6+1 stream from seed 0000001 with in_valid=1 continuously -> locked=0 through valid bit 14, locked=1 after the 15th edge; err_count stays 0 over 500 bits.
2. Locked, flip one bit -> exactly one err_pulse, err_count=1, locked remains 1. The flywheel means the next 7 bits produce no further errors.
3. Locked, flip 4 consecutive bits -> err_count=4, locked falls after the 4th. With a clean stream resumed, it relocks 15 valid bits later.
4. Toggle in_valid 1/0 every cycle on a clean stream -> lock after 15 valid bits (about 30 cycles); no activity on invalid cycles.
5. Feed an all-zero stream -> locked never asserts; err_count=0. Error at count 0xFFFF -> stays 0xFFFF. clear coincident with an error -> err_count=0, err_pulse=1.
6. Assert reset_n low mid-lock with err_count=5 -> locked=0 and err_count=0 immediately (asynchronous); clean relock 15 valid bits after release.
